// File: rtl/display_mode_ctrl.sv
// Purpose: debounced buttons pick the VGA pattern mode and base colour; changes land on frame boundaries.
// Latency: button edge -> press = 2 + DEBOUNCE_CYCLES clk; press -> new state/color = next frame boundary + 1 clk.
// Backpressure: none; presses arriving before the boundary are merged into one pending advance.
module display_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_FRAMES     = 120,
    parameter int NUM_MODES       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_auto,
    input  logic [9:0] hcnt,
    input  logic [9:0] vcnt,
    output logic [1:0] state,
    output logic [2:0] color,
    output logic       auto_en,
    output logic       frame_tick
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int              DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [15:0]     FCNT_LAST = 16'(AUTO_FRAMES - 1);
    localparam logic [1:0]      MODE_LAST = 2'(NUM_MODES - 1);

    // Two-flop synchronizers for the raw buttons.
    logic            next_s1, next_s2;
    logic            auto_s1, auto_s2;

    // Debounced levels and their stability counters.
    logic            next_deb, auto_deb;
    logic [DB_W-1:0] next_cnt, auto_cnt;

    // Frame boundary detection and mode bookkeeping.
    logic            origin_q;
    logic            pend;
    logic [15:0]     fcnt;

    logic            next_press;
    logic            auto_press;
    logic            at_origin;
    logic            fb;
    logic            pend_eff;
    logic            expire;
    logic            adv;

    // A press is the cycle the debounced level is about to rise.
    assign next_press = (next_s2 != next_deb) && (next_cnt == DB_LAST) && next_s2;
    assign auto_press = (auto_s2 != auto_deb) && (auto_cnt == DB_LAST) && auto_s2;

    // Boundary fires once on entry to (0,0), however long the counters dwell there.
    assign at_origin  = (hcnt == 10'd0) && (vcnt == 10'd0);
    assign fb         = at_origin && !origin_q;

    // A press landing on the boundary cycle is served by that boundary.
    assign pend_eff   = pend || next_press;
    assign expire     = auto_en && fb && (fcnt == FCNT_LAST);
    assign adv        = fb && (pend_eff || expire);

    // Bring both buttons into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_s1 <= 1'b0;
            next_s2 <= 1'b0;
            auto_s1 <= 1'b0;
            auto_s2 <= 1'b0;
        end else begin
            next_s1 <= btn_next;
            next_s2 <= next_s1;
            auto_s1 <= btn_auto;
            auto_s2 <= auto_s1;
        end
    end

    // Accept a new btn_next level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_deb <= 1'b0;
            next_cnt <= '0;
        end else if (next_s2 == next_deb) begin
            next_cnt <= '0;
        end else if (next_cnt == DB_LAST) begin
            next_deb <= next_s2;
            next_cnt <= '0;
        end else begin
            next_cnt <= next_cnt + DB_ONE;
        end
    end

    // Same debounce rule for btn_auto.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_deb <= 1'b0;
            auto_cnt <= '0;
        end else if (auto_s2 == auto_deb) begin
            auto_cnt <= '0;
        end else if (auto_cnt == DB_LAST) begin
            auto_deb <= auto_s2;
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + DB_ONE;
        end
    end

    // Remember last cycle's origin flag and publish the boundary one cycle late, aligned with state/color.
    always_ff @(posedge clk) begin
        if (rst) begin
            origin_q   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            origin_q   <= at_origin;
            frame_tick <= fb;
        end
    end

    // Hold one coalesced manual request until the next boundary consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (fb) begin
            pend <= 1'b0;
        end else if (next_press) begin
            pend <= 1'b1;
        end
    end

    // Auto-cycle enable toggles immediately; enabling or any advance restarts the frame interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_en <= 1'b0;
            fcnt    <= 16'd0;
        end else begin
            if (auto_press) begin
                auto_en <= !auto_en;
            end
            if (auto_press && !auto_en) begin
                fcnt <= 16'd0;
            end else if (fb) begin
                if (expire || pend_eff) begin
                    fcnt <= 16'd0;
                end else if (auto_en) begin
                    fcnt <= fcnt + 16'd1;
                end
            end
        end
    end

    // Step the mode select and base colour on each boundary advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 2'd0;
            color <= 3'b100;
        end else if (adv) begin
            state <= (state == MODE_LAST) ? 2'd0 : state + 2'd1;
            color <= color + 3'd1;
        end
    end

endmodule

// File: tb/tb_display_mode_ctrl.sv
module tb_display_mode_ctrl;

    localparam int D  = 4;
    localparam int AF = 3;
    localparam int NM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       btn_auto;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [1:0] state;
    logic [2:0] color;
    logic       auto_en;
    logic       frame_tick;

    display_mode_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .AUTO_FRAMES    (AF),
        .NUM_MODES      (NM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_next  (btn_next),
        .btn_auto  (btn_auto),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .state     (state),
        .color     (color),
        .auto_en   (auto_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: button samples delayed two edges, a window of the last D
    // synchronized values, and the mode expressed as plain integers.
    bit [1:0]   m_rawn, m_rawa;
    bit [D-1:0] m_wn, m_wa;
    int         m_wlen;
    bit         m_debn, m_deba, m_prev0, m_pend, m_auto, m_tick;
    int         m_frames, m_mode, m_color;

    int         dwell;
    int         ticks_seen;
    logic [1:0] pre_state;
    int         nrem, arem;

    function automatic int pos();
        return int'(vcnt) * 8 + int'(hcnt);
    endfunction

    task automatic model_edge();
        bit sn, sa, pn, pa, at0, fb, take, exp_now;
        if (rst) begin
            m_rawn = '0; m_rawa = '0; m_wn = '0; m_wa = '0; m_wlen = 0;
            m_debn = 0; m_deba = 0; m_prev0 = 0; m_pend = 0; m_auto = 0;
            m_frames = 0; m_mode = 0; m_color = 4; m_tick = 0;
        end else begin
            sn = m_rawn[1];
            sa = m_rawa[1];
            m_rawn = {m_rawn[0], btn_next};
            m_rawa = {m_rawa[0], btn_auto};
            m_wn = {m_wn[D-2:0], sn};
            m_wa = {m_wa[D-2:0], sa};
            if (m_wlen < D) m_wlen++;
            pn = 0;
            pa = 0;
            if (m_wlen >= D && m_wn == {D{~m_debn}}) begin
                pn = ~m_debn;
                m_debn = ~m_debn;
            end
            if (m_wlen >= D && m_wa == {D{~m_deba}}) begin
                pa = ~m_deba;
                m_deba = ~m_deba;
            end
            at0 = (hcnt == 10'd0) && (vcnt == 10'd0);
            fb = at0 && !m_prev0;
            m_prev0 = at0;
            m_tick = fb;
            if (fb) begin
                exp_now = m_auto && (m_frames == AF - 1);
                take = m_pend || pn;
                if (take || exp_now) begin
                    m_mode = (m_mode + 1) % NM;
                    m_color = (m_color + 1) % 8;
                    m_frames = 0;
                end else if (m_auto) begin
                    m_frames++;
                end
                m_pend = 0;
            end else if (pn) begin
                m_pend = 1;
            end
            if (pa) begin
                if (!m_auto) m_frames = 0;
                m_auto = !m_auto;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, compare all outputs, move the raster.
    task automatic cyc();
        logic [6:0] obs, expv;
        @(posedge clk);
        model_edge();
        #1;
        obs  = {state, color, auto_en, frame_tick};
        expv = {2'(m_mode), 3'(m_color), m_auto, m_tick};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL cycle_outputs t=%0t observed=%b expected=%b", $time, obs, expv);
        end
        if (frame_tick === 1'b1) ticks_seen++;
        if (dwell > 0) begin
            dwell--;
        end else if (hcnt == 10'd7) begin
            hcnt = 10'd0;
            vcnt = (vcnt == 10'd3) ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt = hcnt + 10'd1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_tick();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            pre_state = state;
            cyc();
            if (m_tick) got = 1;
        end
        chk("tick_timeout", 32'(got), 1);
    endtask

    task automatic wait_pos(input int p);
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (pos() == p) got = 1;
            else cyc();
        end
        chk("pos_timeout", 32'(got), 1);
    endtask

    task automatic press_next(input int n);
        btn_next = 1'b1;
        run(n);
        btn_next = 1'b0;
    endtask

    task automatic press_auto(input int n);
        btn_auto = 1'b1;
        run(n);
        btn_auto = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_next = 1'b0; btn_auto = 1'b0;
        hcnt = 10'd0; vcnt = 10'd0; dwell = 0; ticks_seen = 0;
        nrem = 0; arem = 0;

        // Reset values, then five idle frames.
        run(3);
        chk("rst_state", state, 0);
        chk("rst_color", color, 4);
        chk("rst_tick", frame_tick, 0);
        rst = 1'b0;
        ticks_seen = 0;
        run(160);
        chk("ticks_5_frames", ticks_seen, 5);
        chk("idle_state", state, 0);
        chk("idle_color", color, 4);
        chk("idle_auto", auto_en, 0);

        // Short glitch is filtered.
        press_next(2);
        wait_tick();
        wait_tick();
        chk("glitch_state", state, 0);

        // Held press advances at the next boundary, not before.
        run(3);
        press_next(10);
        wait_tick();
        chk("pre_tick_state", pre_state, 0);
        chk("held_state", state, 1);
        chk("held_color", color, 5);

        // Three presses inside one frame coalesce.
        for (int k = 0; k < 3; k++) begin
            press_next(5);
            run(5);
        end
        wait_tick();
        chk("coalesce_state", state, 2);
        chk("coalesce_color", color, 6);

        // Press completing on the boundary cycle is served by that boundary.
        wait_pos(27);
        btn_next = 1'b1;
        wait_tick();
        chk("fbpress_state", state, 3);
        chk("fbpress_color", color, 7);
        btn_next = 1'b0;
        wait_tick();
        chk("fbpress_nopend", state, 3);

        // Button held through reset release gives exactly one press.
        rst = 1'b1; btn_next = 1'b1;
        run(2);
        rst = 1'b0;
        run(40);
        btn_next = 1'b0;
        wait_tick();
        wait_tick();
        chk("held_rst_state", state, 1);
        chk("held_rst_color", color, 5);

        // Four manual advances wrap the mode and colour.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        wait_tick();
        for (int i = 0; i < 4; i++) begin
            run(2);
            press_next(6);
            wait_tick();
            chk("seq_state", state, (i + 1) % 4);
            chk("seq_color", color, (5 + i) % 8);
        end

        // Auto-cycle every AF frames.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        wait_tick();
        run(2);
        press_auto(6);
        run(2);
        chk("auto_on", auto_en, 1);
        for (int g = 1; g <= 9; g++) begin
            wait_tick();
            chk("auto_state", state, (g / 3) % 4);
            chk("auto_color", color, (4 + g / 3) % 8);
        end

        // Manual advance restarts the auto interval.
        run(2);
        press_next(6);
        wait_tick();
        chk("man_state", state, 0);
        chk("man_color", color, 0);
        wait_tick();
        wait_tick();
        chk("restart_hold", state, 0);
        wait_tick();
        chk("restart_adv", state, 1);
        chk("restart_color", color, 1);

        // Manual and auto on the same boundary give one step.
        wait_tick();
        wait_tick();
        chk("coinc_pre", state, 1);
        run(2);
        press_next(6);
        wait_tick();
        chk("coinc_state", state, 2);
        chk("coinc_color", color, 2);
        wait_tick();
        wait_tick();
        chk("coinc_hold", state, 2);
        wait_tick();
        chk("coinc_next", state, 3);

        // Reset mid-frame with a pending request and auto enabled.
        run(2);
        press_next(6);
        run(4);
        chk("pre_rst_auto", auto_en, 1);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(1);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_color", color, 4);
        chk("mid_rst_auto", auto_en, 0);
        chk("mid_rst_tick", frame_tick, 0);
        wait_tick();
        chk("post_rst_state", state, 0);
        chk("post_rst_color", color, 4);

        // Counters dwelling at the origin produce one tick.
        wait_pos(0);
        dwell = 2;
        ticks_seen = 0;
        run(20);
        chk("dwell_ticks", ticks_seen, 1);

        // Random buttons, occasional reset and origin dwell, checked every cycle.
        for (int c = 0; c < 3000; c++) begin
            if (nrem == 0) begin
                btn_next = 1'($urandom_range(0, 1));
                nrem = $urandom_range(1, 10);
            end
            nrem--;
            if (arem == 0) begin
                btn_auto = 1'($urandom_range(0, 1));
                arem = $urandom_range(1, 40);
            end
            arem--;
            rst = ($urandom_range(0, 599) == 0);
            if (pos() == 0 && dwell == 0 && $urandom_range(0, 3) == 0)
                dwell = $urandom_range(1, 3);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
